tdm_mux: RTL
============

TDM_MUX -- requirements
Module: tdm_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel.
REQ-002 SHALL have parameter CHANNELS, default 4, input channel count; power of two, 2..16.
REQ-003 SHALL have localparam SEL_W = clog2(CHANNELS), channel index width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port din  input  CHANNELS*WIDTH  channel data; channel k at bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid  input  CHANNELS  per-channel data-present flag.
REQ-008 SHALL have port in_ack  output  CHANNELS  one-hot; channel captured this cycle.
REQ-009 SHALL have port sel  input  SEL_W  channel select, manual mode.
REQ-010 SHALL have port mode  input  1  0 = manual select, 1 = round-robin scan.
REQ-011 SHALL have port out_ready  input  1  downstream accepts dout this cycle.
REQ-012 SHALL have port dout  output  WIDTH  registered selected data.
REQ-013 SHALL have port dout_ch  output  SEL_W  channel index of dout.
REQ-014 SHALL have port dout_valid  output  1  dout holds an unconsumed word.

Function
REQ-015 SHALL define load = !dout_valid || out_ready; output registers update only when load=1, else hold dout/dout_ch/dout_valid.
REQ-016 Manual mode, load=1, in_valid[sel]=1: SHALL capture din[sel], set dout_ch=sel, dout_valid=1, in_ack[sel]=1.
REQ-017 Manual mode, load=1, in_valid[sel]=0: SHALL set dout_valid=0; dout/dout_ch hold; in_ack=0.
REQ-018 Scan mode: SHALL pick winner = first k with in_valid[k]=1 searching ptr, ptr+1, ... wrapping modulo CHANNELS.
REQ-019 Scan mode, load=1, winner exists: SHALL capture din[winner], dout_ch=winner, dout_valid=1, in_ack[winner]=1, ptr <= (winner+1) mod CHANNELS.
REQ-020 Scan mode, load=1, no in_valid set: SHALL set dout_valid=0, ptr unchanged, in_ack=0.
REQ-021 Wrap-around: winner=CHANNELS-1 SHALL set ptr=0.
REQ-022 in_ack SHALL be combinational, at most one bit high, and zero whenever load=0.
REQ-023 Latency SHALL be one cycle from in_ack edge to dout_valid=1; full throughput (one word/cycle) with out_ready held 1.
REQ-024 While mode=0, ptr SHALL be cleared to 0 each cycle; a mode change takes effect on the next load.
REQ-025 Stall (dout_valid=1, out_ready=0) SHALL hold all outputs stable and hold ptr regardless of in_valid, sel, mode.

Reset
REQ-026 rst_n=0 SHALL immediately force dout=0, dout_ch=0, dout_valid=0, ptr=0 (and dout_par=0 when built).
REQ-027 in_ack SHALL be 0 while rst_n=0; reset mid-transfer discards held word; first capture on first rising edge after release.

Configuration
REQ-028 Macro TDM_MUX_PARITY_EN defined: SHALL add output dout_par (1 bit) = even parity (XOR) of captured word, registered with dout under REQ-015.
REQ-029 Macro TDM_MUX_PARITY_EN undefined: dout_par port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Manual: mode=0, sel=2, in_valid=4'b0100, din ch2=8'hA5, out_ready=1 -> in_ack=4'b0100; next cycle dout=8'hA5, dout_ch=2, dout_valid=1.
REQ-031 Scan: mode=1, in_valid=4'b1111, out_ready=1, 5 cycles -> dout_ch sequence 0,1,2,3,0; in_ack one-hot each cycle.
REQ-032 Skip/wrap: mode=1, ptr=3, in_valid=4'b0010 -> winner 1, next ptr=2; in_valid=4'b0000 -> dout_valid=0, ptr stays 2.
REQ-033 Backpressure: dout_valid=1, out_ready=0 for 3 cycles, in_valid=4'b1111 -> dout/dout_ch constant, in_ack=0, ptr constant; out_ready=1 resumes at ptr.
REQ-034 Reset: assert rst_n=0 mid-stream between clock edges -> dout_valid=0, dout=0 without a clock edge; after release, scan restarts at channel 0.
REQ-035 Parity (TDM_MUX_PARITY_EN defined): capture 8'h07 -> dout_par=1; capture 8'h03 -> dout_par=0.

Source files
------------

// File: rtl/tdm_mux.sv
// tdm_mux: TDM multiplexer, manual channel select or round-robin scan into a registered output with backpressure.
// Define TDM_MUX_PARITY_EN to add the dout_par even-parity output.
module tdm_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ack,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          dout,
  output logic [SEL_W-1:0]          dout_ch,
`ifdef TDM_MUX_PARITY_EN
  output logic                      dout_par,
`endif
  output logic                      dout_valid
);
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SEL_W-1:0] ch_q, ch_d, ptr_q, ptr_d, win;
  logic             valid_q, valid_d, hit, load;
  assign load = !valid_q || out_ready;
  // Descending search so the channel closest to ptr wins the last assignment.
  always_comb begin
    hit = 1'b0;
    win = sel;
    if (mode) begin
      win = ptr_q;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (in_valid[ptr_q + SEL_W'(i)]) begin
          hit = 1'b1;
          win = ptr_q + SEL_W'(i);
        end
      end
    end else begin
      hit = in_valid[sel];
    end
  end
  assign in_ack  = (rst_n && load && hit) ? (CHANNELS'(1) << win) : '0;
  assign dout_d  = (load && hit) ? din[win*WIDTH +: WIDTH] : dout_q;
  assign ch_d    = (load && hit) ? win : ch_q;
  assign valid_d = load ? hit : valid_q;
  assign ptr_d   = !load ? ptr_q : !mode ? '0 : hit ? win + SEL_W'(1) : ptr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      dout_q  <= dout_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end
`ifdef TDM_MUX_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else if (load && hit) par_q <= ^din[win*WIDTH +: WIDTH];
  end
  assign dout_par = par_q;
`endif
  assign dout       = dout_q;
  assign dout_ch    = ch_q;
  assign dout_valid = valid_q;
endmodule
